// File: rtl/odd_parity_pkg.sv
// Shared state encoding, line levels and frame-length helper for the odd-parity transmitter.
package odd_parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Clock cycles that busy stays high for one frame: start + data + parity + stop.
    function automatic int frame_cycles(input int data_w, input int clks_per_bit);
        return (data_w + 32'sd3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/odd_parity_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module odd_parity_bit_timer
    import odd_parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // With a single cycle per bit LAST is zero, so bit_done stays high permanently.
    assign bit_done = (cnt_r == LAST);

    // Cycle counter, held at zero whenever the link is idle or a new frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr || !en || bit_done) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter: start bit, DATA_W data bits LSB-first, odd parity, stop bit.
// Define ODD_PARITY_TX_ERR_INJECT_EN to add inject_err, which corrupts the transmitted parity bit.
module odd_parity_serial_tx
    import odd_parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              parity_out
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_r;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shifted_s;
    logic [BW-1:0]     bit_cnt_r;
    logic              tx_par_r;
    logic              accept_s;
    logic              inject_s;
    logic              bit_done_s;
    logic              timer_en_s;

    assign accept_s   = valid_in && ready_out;
    assign shifted_s  = shreg_r >> 1'b1;
    assign timer_en_s = (state_r != IDLE);

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    assign inject_s = inject_err;
`else
    assign inject_s = 1'b0;
`endif

    odd_parity_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (timer_en_s),
        .clr     (accept_s),
        .bit_done(bit_done_s)
    );

    // Frame sequencer with registered line, handshake and parity outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            bit_cnt_r  <= '0;
            tx_par_r   <= 1'b0;
            parity_out <= 1'b0;
            tx         <= IDLE_LVL;
            busy       <= 1'b0;
            ready_out  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shreg_r    <= data_in;
                        parity_out <= ~^data_in;
                        // parity_out stays truthful; only the bit on the wire is corrupted
                        tx_par_r   <= (~^data_in) ^ inject_s;
                        bit_cnt_r  <= '0;
                        tx         <= START_LVL;
                        busy       <= 1'b1;
                        ready_out  <= 1'b0;
                        state_r    <= START;
                    end else begin
                        tx        <= IDLE_LVL;
                        busy      <= 1'b0;
                        ready_out <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        tx      <= shreg_r[0];
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            tx      <= tx_par_r;
                            state_r <= PARITY;
                        end else begin
                            shreg_r   <= shifted_s;
                            tx        <= shifted_s[0];
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done_s) begin
                        tx      <= STOP_LVL;
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        tx        <= IDLE_LVL;
                        busy      <= 1'b0;
                        ready_out <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    tx        <= IDLE_LVL;
                    busy      <= 1'b0;
                    ready_out <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Self-checking bench for odd_parity_serial_tx: 4-bit/4-clock instance plus an 8-bit/1-clock instance.
module tb_odd_parity_serial_tx;
    import odd_parity_pkg::*;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int F   = frame_cycles(DW, CPB);
    localparam int F8  = frame_cycles(8, 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
    logic          inject_err = 1'b0;
`endif
    logic          ready_out, tx, busy, parity_out;

    logic [7:0]    d8_data = 8'h00;
    logic          d8_valid = 1'b0;
    logic          d8_ready, d8_tx, d8_busy, d8_parity;

    logic [15:0]   rx_bits;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    odd_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy),
        .parity_out(parity_out)
    );

    odd_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (d8_data),
        .valid_in  (d8_valid),
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        .inject_err(1'b0),
`endif
        .ready_out (d8_ready),
        .tx        (d8_tx),
        .busy      (d8_busy),
        .parity_out(d8_parity)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chkv(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Odd parity by counting ones: 1 when the word has an even number of ones.
    function automatic logic odd_par(input logic [7:0] w);
        return (($countones(w) % 2) == 0);
    endfunction

    // Expected line level at bit position p of a frame carrying an nbits-wide word.
    function automatic logic exp_bit(input logic [7:0] w, input int nbits, input int p, input logic inj);
        if (p == 0) return 1'b0;
        else if (p <= nbits) return w[p-1];
        else if (p == nbits + 1) return odd_par(w) ^ inj;
        else return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_busy_cycle(input logic [7:0] w, input int o, input logic inj);
        chk("busy", busy, 1'b1);
        chk("ready_low", ready_out, 1'b0);
        chk($sformatf("tx_bit%0d_cyc%0d", o / CPB, o), tx, exp_bit(w, DW, o / CPB, inj));
        if (o % CPB == CPB / 2) rx_bits[o / CPB] = tx;
    endtask

    task automatic check_idle_cycle();
        chk("idle_busy", busy, 1'b0);
        chk("idle_tx", tx, 1'b1);
        chk("idle_ready", ready_out, 1'b1);
    endtask

    // Receiver-side view: recover the word and apply the odd-parity check.
    task automatic check_rx(input logic [7:0] w, input logic inj);
        logic [7:0] rxd;
        rxd = 8'h00;
        rxd[DW-1:0] = rx_bits[DW:1];
        chkv("rx_data", rxd, w);
        chk("rx_err", ($countones(rx_bits[DW+1:1]) % 2) == 0, inj);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("wait_ready", ready_out, 1'b1);
    endtask

    task automatic send_word(input logic [7:0] w, input logic inj);
        wait_ready();
        data_in  = w[DW-1:0];
        valid_in = 1'b1;
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        inject_err = inj;
`endif
        tick();
        valid_in = 1'b0;
        data_in  = DW'($urandom);
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        chk("parity_out", parity_out, odd_par(w));
        rx_bits = '0;
        for (int o = 0; o < F; o++) begin
            check_busy_cycle(w, o, inj);
            tick();
        end
        check_idle_cycle();
        check_rx(w, inj);
    endtask

    // valid_in held high with fresh data every cycle; only frame-boundary words go out.
    task automatic stream(input int nframes);
        logic [7:0] cur;
        logic [7:0] w;
        cur = 8'h00;
        wait_ready();
        valid_in = 1'b1;
        for (int j = 0; j < nframes * (F + 1); j++) begin
            w = 8'($urandom_range(0, 15));
            data_in = w[DW-1:0];
            tick();
            if (j % (F + 1) == 0) begin
                cur = w;
                rx_bits = '0;
                chk("stream_parity_out", parity_out, odd_par(cur));
            end
            if (j % (F + 1) < F) begin
                check_busy_cycle(cur, j % (F + 1), 1'b0);
            end else begin
                check_idle_cycle();
                check_rx(cur, 1'b0);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic send8(input logic [7:0] w);
        int n;
        n = 0;
        while (d8_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("d8_wait_ready", d8_ready, 1'b1);
        d8_data  = w;
        d8_valid = 1'b1;
        tick();
        d8_valid = 1'b0;
        chk("d8_parity_out", d8_parity, odd_par(w));
        for (int o = 0; o < F8; o++) begin
            chk("d8_busy", d8_busy, 1'b1);
            chk($sformatf("d8_tx_cyc%0d", o), d8_tx, exp_bit(w, 8, o, 1'b0));
            tick();
        end
        chk("d8_idle_busy", d8_busy, 1'b0);
        chk("d8_idle_tx", d8_tx, 1'b1);
        chk("d8_idle_ready", d8_ready, 1'b1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_parity_out", parity_out, 1'b0);
        chk("rst_d8_tx", d8_tx, 1'b1);
        chk("rst_d8_ready", d8_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle_cycle();

        send_word(8'h00, 1'b0);
        send_word(8'h0B, 1'b0);
        send_word(8'h0F, 1'b0);
        send_word(8'h07, 1'b0);
        for (int w = 0; w < 16; w++) send_word(8'(w), 1'b0);
        for (int k = 0; k < 6; k++) send_word(8'($urandom_range(0, 15)), 1'b0);

        stream(3);

        // Abort a frame of 4'b0101 while its data bits are on the line.
        wait_ready();
        data_in  = 4'b0101;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (2 * CPB + 1) tick();
        chk("pre_abort_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready_out, 1'b1);
        chk("abort_parity_out", parity_out, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < F; k++) begin
            tick();
            chk("no_resume_tx", tx, 1'b1);
            chk("no_resume_busy", busy, 1'b0);
        end
        send_word(8'($urandom_range(0, 15)), 1'b0);

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
        send_word(8'h07, 1'b1);
        send_word(8'h07, 1'b0);
`endif

        send8(8'hA5);
        for (int k = 0; k < 3; k++) send8(8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
